p2s_serializer: RTL and testbench

Parametrised parallel-to-serial shifter that drives the LED/segment shift-register chain (74HC164/595-style) from a parallel word. It generalises the existing 7-bit P2S with:
- configurable width and bit order
- a programmable serial-clock divider
- a storage-latch pulse
- a start/busy/done handshake
- a registered, glitch-free output stage

It sits between the display controller and the board-level shift-register pins.

---
 rtl/p2s_serializer_pkg.sv | 15 +
 rtl/p2s_serializer_if.sv | 25 ++
 rtl/p2s_serializer_phase_gen.sv | 22 ++
 rtl/p2s_serializer.sv | 120 ++++++++++++
 tb/tb_p2s_serializer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/p2s_serializer_pkg.sv
// Shared definitions for the parallel-to-serial shift-register driver:
// FSM state encodings and the parameter legality check.
package p2s_serializer_pkg;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] SHIFT_LO = 2'd1;
   localparam logic [1:0] SHIFT_HI = 2'd2;
   localparam logic [1:0] LATCH    = 2'd3;

   function automatic bit params_ok(input int data_width, input int clk_div,
                                    input int latch_pulse);
      return (data_width >= 1) && (clk_div >= 1) && (latch_pulse >= 1);
   endfunction

endpackage

// File: rtl/p2s_serializer_if.sv
// Handshake and shift-register-chain signals of the serializer.
// The master side is the display controller, the slave side the serializer.
interface p2s_serializer_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  start;
   logic [DATA_WIDTH-1:0] par_in;
   logic                  ready;
   logic                  busy;
   logic                  done;
   logic                  sclk;
   logic                  sout;
   logic                  latch;
   logic                  sclrn;

   modport master (
      output start, par_in,
      input  ready, busy, done, sclk, sout, latch, sclrn
   );

   modport slave (
      input  start, par_in,
      output ready, busy, done, sclk, sout, latch, sclrn
   );
endinterface

// File: rtl/p2s_serializer_phase_gen.sv
// Serial-clock half-period timer: self-reloading down-counter that ticks on
// the last clk cycle of every CLK_DIV-cycle half-period.
module p2s_phase_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic phase_tick
);
   localparam int              CW     = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0]   RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear || cnt == '0) cnt <= RELOAD;
      else                           cnt <= cnt - 1'b1;
   end

   assign phase_tick = !clear && (cnt == '0);
endmodule

// File: rtl/p2s_serializer.sv
// Parallel-to-serial driver for a 74HC164/595-style chain: shifts a captured
// word out on sout/sclk, then pulses the storage latch and reports done.
module p2s_serializer
   import p2s_serializer_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int CLK_DIV     = 2,
   parameter bit MSB_FIRST   = 1'b1,
   parameter int LATCH_PULSE = 1
) (
   input logic               clk,
   input logic               rst,
   p2s_serializer_if.slave   bus
);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam int LW = $clog2(LATCH_PULSE + 1);

   if (!params_ok(DATA_WIDTH, CLK_DIV, LATCH_PULSE)) begin : g_param_check
      $error("p2s_serializer: DATA_WIDTH, CLK_DIV and LATCH_PULSE must all be >= 1");
   end

   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
   logic [BW-1:0]         bit_cnt, bit_cnt_dec;
   logic [LW-1:0]         lat_cnt;
   logic                  sclk_q, sout_q, latch_q, busy_q, done_q, ready_q, sclrn_q;
   logic                  phase_clear, phase_tick;

   // The divider only runs while bits are being clocked out.
   assign phase_clear = (state == IDLE) || (state == LATCH);

   p2s_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
      .clk        (clk),
      .rst        (rst),
      .clear      (phase_clear),
      .phase_tick (phase_tick)
   );

   function automatic logic head(input logic [DATA_WIDTH-1:0] w);
      return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
   endfunction

   always_comb begin
      shreg_nxt   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
      bit_cnt_dec = bit_cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         lat_cnt <= '0;
         sclk_q  <= 1'b0;
         sout_q  <= 1'b0;
         latch_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         sclrn_q <= 1'b0;
      end else begin
         sclrn_q <= 1'b1;
         done_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  shreg   <= bus.par_in;
                  bit_cnt <= BW'(DATA_WIDTH);
                  sout_q  <= head(bus.par_in);
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
                  state   <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (phase_tick) begin
                  sclk_q <= 1'b1;
                  state  <= SHIFT_HI;
               end
            end
            SHIFT_HI: begin
               if (phase_tick) begin
                  sclk_q  <= 1'b0;
                  bit_cnt <= bit_cnt_dec;
                  if (bit_cnt_dec == '0) begin
                     latch_q <= 1'b1;
                     lat_cnt <= LW'(LATCH_PULSE - 1);
                     state   <= LATCH;
                  end else begin
                     shreg  <= shreg_nxt;
                     sout_q <= head(shreg_nxt);
                     state  <= SHIFT_LO;
                  end
               end
            end
            LATCH: begin
               if (lat_cnt == '0) begin
                  latch_q <= 1'b0;
                  sout_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
                  state   <= IDLE;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.sclk  = sclk_q;
   assign bus.sout  = sout_q;
   assign bus.latch = latch_q;
   assign bus.sclrn = sclrn_q;
endmodule

// File: tb/tb_p2s_serializer.sv
// Bench for p2s_serializer: four parameter sets run directed transfers while a
// scoreboard monitor checks serial bits, phase widths, latch and done timing.
module tb_p2s_serializer;
   localparam int NI = 4;

   function automatic int dw_of(input int i);
      case (i) 0: return 8; 1: return 8; 2: return 1; default: return 16; endcase
   endfunction
   function automatic int cd_of(input int i);
      return (i == 2) ? 1 : 2;
   endfunction
   function automatic int msb_of(input int i);
      return (i == 1) ? 0 : 1;
   endfunction
   function automatic int lp_of(input int i);
      return (i == 2) ? 3 : 1;
   endfunction

   typedef struct {
      int busy_len;   // 0 marks a transfer expected to be aborted by reset
      int latch_len;
      int nbits;
      int half;
   } xfer_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_v [NI];
   logic [15:0] par_v   [NI];
   logic        ready_v [NI], busy_v [NI], done_v [NI], sclk_v [NI];
   logic        sout_v  [NI], latch_v[NI], sclrn_v[NI];

   int n_checks = 0;
   int n_fail   = 0;

   bit    exp_bits [NI][$];
   xfer_t exp_x    [NI][$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int DW = dw_of(g);
      p2s_serializer_if #(.DATA_WIDTH(DW)) bus ();
      assign bus.start  = start_v[g];
      assign bus.par_in = par_v[g][DW-1:0];
      assign ready_v[g] = bus.ready;
      assign busy_v[g]  = bus.busy;
      assign done_v[g]  = bus.done;
      assign sclk_v[g]  = bus.sclk;
      assign sout_v[g]  = bus.sout;
      assign latch_v[g] = bus.latch;
      assign sclrn_v[g] = bus.sclrn;

      p2s_serializer #(
         .DATA_WIDTH  (DW),
         .CLK_DIV     (cd_of(g)),
         .MSB_FIRST   (msb_of(g) != 0),
         .LATCH_PULSE (lp_of(g))
      ) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event not expected by scoreboard", name);
   endtask

   task automatic expect_xfer(input int i, input logic [15:0] w, input int nbits,
                              input int busy_len, input int latch_len, input int half);
      xfer_t x;
      for (int b = 0; b < nbits; b++)
         exp_bits[i].push_back(w[(msb_of(i) != 0) ? dw_of(i) - 1 - b : b]);
      x.busy_len  = busy_len;
      x.latch_len = latch_len;
      x.nbits     = nbits;
      x.half      = half;
      exp_x[i].push_back(x);
   endtask

   // Called one step after a rising edge with the instance idle.
   task automatic start_xfer(input int i, input logic [15:0] w);
      par_v[i]   = w;
      start_v[i] = 1'b1;
      @(posedge clk); #1;
      start_v[i] = 1'b0;
      par_v[i]   = ~w;
   endtask

   task automatic wait_idle(input int i);
      int c = 0;
      while (!(ready_v[i] === 1'b1 && busy_v[i] === 1'b0) && c < 300) begin
         @(posedge clk); #1;
         c++;
      end
      if (c >= 300) flag($sformatf("idle_timeout[%0d]", i));
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input int i);
      check($sformatf("rst_sclk[%0d]", i),  sclk_v[i],  0);
      check($sformatf("rst_sout[%0d]", i),  sout_v[i],  0);
      check($sformatf("rst_latch[%0d]", i), latch_v[i], 0);
      check($sformatf("rst_busy[%0d]", i),  busy_v[i],  0);
      check($sformatf("rst_done[%0d]", i),  done_v[i],  0);
      check($sformatf("rst_ready[%0d]", i), ready_v[i], 1);
      check($sformatf("rst_sclrn[%0d]", i), sclrn_v[i], 0);
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   bit    active [NI];
   bit    sclk_prev [NI], latch_prev [NI];
   int    cyc [NI], busy_cnt [NI], latch_cnt [NI], rises [NI], run [NI];
   xfer_t mx;
   bit    eb;

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            if (active[i]) begin
               if (exp_x[i].size() == 0 || exp_x[i][0].busy_len != 0) begin
                  flag($sformatf("abort[%0d]", i));
               end else begin
                  mx = exp_x[i].pop_front();
                  check($sformatf("abort_rises[%0d]", i), rises[i], mx.nbits);
                  check($sformatf("abort_latch[%0d]", i), latch_cnt[i], 0);
               end
               active[i] = 1'b0;
            end
         end else begin
            if (active[i]) begin
               mx = exp_x[i][0];
               cyc[i]++;
               if (busy_v[i])  busy_cnt[i]++;
               if (latch_v[i]) latch_cnt[i]++;
               if (sclk_v[i] !== sclk_prev[i]) begin
                  check($sformatf("sclk_phase[%0d]", i), run[i], mx.half);
                  run[i] = 1;
                  if (sclk_v[i]) begin
                     rises[i]++;
                     if (exp_bits[i].size() == 0) flag($sformatf("extra_bit[%0d]", i));
                     else begin
                        eb = exp_bits[i].pop_front();
                        check($sformatf("bit%0d[%0d]", rises[i], i), sout_v[i], eb);
                     end
                  end
               end else begin
                  run[i]++;
               end
               if (latch_v[i] && !latch_prev[i]) begin
                  check($sformatf("latch_start[%0d]", i), cyc[i], mx.busy_len - mx.latch_len + 1);
                  check($sformatf("latch_after_bits[%0d]", i), rises[i], mx.nbits);
               end
               if (done_v[i]) begin
                  mx = exp_x[i].pop_front();
                  check($sformatf("done_cycle[%0d]", i), cyc[i], mx.busy_len + 1);
                  check($sformatf("busy_len[%0d]", i), busy_cnt[i], mx.busy_len);
                  check($sformatf("latch_len[%0d]", i), latch_cnt[i], mx.latch_len);
                  check($sformatf("rises[%0d]", i), rises[i], mx.nbits);
                  check($sformatf("idle_sout[%0d]", i), sout_v[i], 0);
                  check($sformatf("done_ready[%0d]", i), ready_v[i], 1);
                  active[i] = 1'b0;
               end else begin
                  check($sformatf("ready_low[%0d]", i), ready_v[i], 0);
                  if (cyc[i] > 300) begin
                     flag($sformatf("done_timeout[%0d]", i));
                     void'(exp_x[i].pop_front());
                     active[i] = 1'b0;
                  end
               end
            end else begin
               if (done_v[i]) flag($sformatf("spurious_done[%0d]", i));
               if (sclk_v[i] && !sclk_prev[i]) flag($sformatf("spurious_sclk[%0d]", i));
               if (latch_v[i] && !latch_prev[i]) flag($sformatf("spurious_latch[%0d]", i));
            end
            if (!active[i] && ready_v[i] === 1'b1 && start_v[i] === 1'b1) begin
               if (exp_x[i].size() == 0) begin
                  flag($sformatf("unexpected_start[%0d]", i));
               end else begin
                  active[i]    = 1'b1;
                  cyc[i]       = 0;
                  busy_cnt[i]  = 0;
                  latch_cnt[i] = 0;
                  rises[i]     = 0;
                  run[i]       = 0;
               end
            end
         end
         sclk_prev[i]  = sclk_v[i];
         latch_prev[i] = latch_v[i];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NI; i++) begin
         start_v[i] = 1'b0;
         par_v[i]   = '0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) check_reset_outputs(i);
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) check($sformatf("sclrn_rise[%0d]", i), sclrn_v[i], 1);

      // MSB-first 8-bit word: 1,0,1,0,0,1,0,1
      expect_xfer(0, 16'h00A5, 8, 33, 1, 2);
      start_xfer(0, 16'h00A5);
      wait_idle(0);

      // LSB-first: a single leading 1 then seven 0s
      expect_xfer(1, 16'h0001, 8, 33, 1, 2);
      start_xfer(1, 16'h0001);
      wait_idle(1);

      // Minimum width and divider, stretched latch
      expect_xfer(2, 16'h0001, 1, 5, 3, 1);
      start_xfer(2, 16'h0001);
      wait_idle(2);

      // Start held high: back-to-back transfers, par_in changes while busy
      for (int j = 0; j < 3; j++)
         expect_xfer(3, (j % 2 == 0) ? 16'hFFFF : 16'h0000, 16, 65, 1, 2);
      par_v[3]   = 16'hFFFF;
      start_v[3] = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(posedge clk); #1;
         if (j == 2) start_v[3] = 1'b0;
         par_v[3] = (j % 2 == 0) ? 16'h0000 : 16'hFFFF;
         repeat (65) @(posedge clk);
         #1;
      end
      wait_idle(3);

      // Reset after three bits of 8'h3C (bits 0,0,1), then a clean transfer
      expect_xfer(0, 16'h003C, 3, 0, 0, 2);
      start_xfer(0, 16'h003C);
      repeat (12) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs(0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("sclrn_after_abort", sclrn_v[0], 1);
      expect_xfer(0, 16'h00C3, 8, 33, 1, 2);
      start_xfer(0, 16'h00C3);
      wait_idle(0);

      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("bits_left[%0d]", i), exp_bits[i].size(), 0);
         check($sformatf("xfers_left[%0d]", i), exp_x[i].size(), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
